// File: rtl/muldiv_seq.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide, one bit per clock.
// Optional MULDIV_SEQ_FAST_EN: zero-operand ops skip the iteration phase and go straight to FIX.
module muldiv_seq #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        funct3;
  logic              sign1, sign2, div_zero, div_ovf;
  logic [XLEN-1:0]   op1, opb, result;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              ready, valid;

  logic              op1_signed, op2_signed, in_sign1, in_sign2, in_div, in_fast;
  logic [XLEN-1:0]   in_mag1, in_mag2;

  always_comb begin
    op1_signed = (i_funct3 == 3'd1) || (i_funct3 == 3'd2) || (i_funct3 == 3'd4) || (i_funct3 == 3'd6);
    op2_signed = (i_funct3 == 3'd1) || (i_funct3 == 3'd4) || (i_funct3 == 3'd6);
    in_sign1   = op1_signed & i_op1[XLEN-1];
    in_sign2   = op2_signed & i_op2[XLEN-1];
    // -MIN_NEG wraps to 2^(XLEN-1), which is the correct unsigned magnitude
    in_mag1    = in_sign1 ? -i_op1 : i_op1;
    in_mag2    = in_sign2 ? -i_op2 : i_op2;
    in_div     = i_funct3[2];
`ifdef MULDIV_SEQ_FAST_EN
    in_fast    = in_div ? (i_op2 == '0) : ((i_op1 == '0) || (i_op2 == '0));
`else
    in_fast    = 1'b0;
`endif
  end

  // acc holds {high partial product, multiplier} for mul and {remainder, dividend/quotient} for div
  logic [XLEN:0]     hi_sum, trial;
  logic [XLEN-1:0]   rem_new;
  logic              ge;
  logic [2*XLEN-1:0] step;

  always_comb begin
    hi_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    trial   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge      = trial >= {1'b0, opb};
    rem_new = ge ? (trial[XLEN-1:0] - opb) : trial[XLEN-1:0];
    step    = funct3[2] ? {rem_new, acc[XLEN-2:0], ge} : {hi_sum, acc[XLEN-1:1]};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_result;

  always_comb begin
    prod = (sign1 ^ sign2) ? -acc : acc;
    quo  = (sign1 ^ sign2) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = sign1 ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (div_zero) begin
      quo = '1;
      rem = op1;
    end else if (div_ovf) begin
      quo = op1;
      rem = '0;
    end
    case (funct3)
      3'd0:             fix_result = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_result = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fix_result = quo;
      default:          fix_result = rem;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      funct3   <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      op1      <= '0;
      opb      <= '0;
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
      ready    <= 1'b1;
      valid    <= 1'b0;
    end else if (i_flush) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b1;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_valid && ready) begin
          funct3   <= i_funct3;
          sign1    <= in_sign1;
          sign2    <= in_sign2;
          op1      <= i_op1;
          opb      <= in_div ? in_mag2 : in_mag1;
          acc      <= in_fast ? '0 : {{XLEN{1'b0}}, (in_div ? in_mag1 : in_mag2)};
          div_zero <= in_div && (i_op2 == '0);
          div_ovf  <= in_div && !i_funct3[0] && (i_op1 == MIN_NEG) && (i_op2 == '1);
          cnt      <= '0;
          ready    <= 1'b0;
          state    <= in_fast ? FIX : CALC;
        end
        CALC: begin
          acc <= step;
          if (cnt == CNT_W'(XLEN - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          result <= fix_result;
          valid  <= 1'b1;
          state  <= DONE;
        end
        DONE: if (i_ready) begin
          valid <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ready  = ready;
  assign o_valid  = valid;
  assign o_result = result;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq (XLEN=32); latency expectations follow MULDIV_SEQ_FAST_EN.
module tb_muldiv_seq;
  logic        clk;
  logic        i_reset_n, i_flush, i_valid, i_ready;
  logic [2:0]  i_funct3;
  logic [31:0] i_op1, i_op2;
  logic        o_ready, o_valid;
  logic [31:0] o_result;

  int tests = 0;
  int fails = 0;
  logic [31:0] scoreboard[$];

  muldiv_seq #(.XLEN(32)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_funct3(i_funct3), .i_op1(i_op1), .i_op2(i_op2),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sbv; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sbv; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // edges counted from the accept edge (inclusive) until o_valid is seen
  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_SEQ_FAST_EN
    if (f3[2] ? (b == 32'd0) : (a == 32'd0 || b == 32'd0)) return 2;
`endif
    return 34;
  endfunction

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input string name);
    int cyc;
    int lat;
    logic [31:0] exp_v;
    cyc = 0;
    while (!o_ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (!o_ready) begin
      tests++; fails++;
      $display("FAIL %s: o_ready=%0b required 1 before issue", name, o_ready);
      return;
    end
    i_funct3 = f3; i_op1 = a; i_op2 = b; i_valid = 1'b1;
    scoreboard.push_back(ref_model(f3, a, b));
    lat = exp_lat(f3, a, b);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_op1 = $urandom; i_op2 = $urandom;
    cyc = 1;
    while (!o_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
    tests++;
    if (!o_valid) begin
      fails++;
      $display("FAIL %s_timeout: o_valid=0 after %0d clocks, required 1", name, cyc);
      void'(scoreboard.pop_front());
      return;
    end
    exp_v = scoreboard.pop_front();
    if (o_result !== exp_v) begin
      fails++;
      $display("FAIL %s_result: got %08h required %08h", name, o_result, exp_v);
    end
    tests++;
    if (cyc !== lat) begin
      fails++;
      $display("FAIL %s_latency: got %0d required %0d", name, cyc, lat);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      tests++;
      if (o_valid !== 1'b1 || o_result !== exp_v || o_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s_hold%0d: valid=%0b ready=%0b result=%08h required 1 0 %08h",
                 name, k, o_valid, o_ready, o_result, exp_v);
      end
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_release: ready=%0b valid=%0b required 1 0", name, o_ready, o_valid);
    end
    $display("[TB] %s f3=%0d op1=%08h op2=%08h -> %08h (latency %0d)", name, f3, a, b, o_result, cyc);
  endtask

  task automatic expect_quiet(input int n, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL %s: %0d cycles not idle, required 0", name, seen);
    end
  endtask

  task automatic test_reset();
    tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: ready=%0b valid=%0b result=%08h required 1 0 0", o_ready, o_valid, o_result);
    end
    i_reset_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ready=%0b valid=%0b required 1 0", o_ready, o_valid);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_mul();
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
    do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh_min");
    do_op(3'd1, 32'hFFFF_FFF9, 32'd3, 0, "mulh_neg");
  endtask

  task automatic test_div();
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem_neg");
    do_op(3'd5, 32'd7, 32'd2, 0, "divu");
    do_op(3'd7, 32'd7, 32'd2, 0, "remu");
    do_op(3'd6, 32'd7, 32'hFFFF_FFFE, 0, "rem_negdiv");
  endtask

  task automatic test_boundary();
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    do_op(3'd5, 32'h1234_5678, 32'd0, 0, "divu_zero");
    do_op(3'd6, 32'd5, 32'd0, 0, "rem_zero");
    do_op(3'd4, 32'hFFFF_FFF0, 32'd0, 0, "div_zero");
    do_op(3'd0, 32'd0, 32'hDEAD_BEEF, 0, "mul_zero");
  endtask

  task automatic test_hold();
    do_op(3'd0, 32'd1234, 32'd5678, 10, "hold");
  endtask

  task automatic test_flush();
    i_funct3 = 3'd4; i_op1 = 32'd100; i_op2 = 32'd7; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle: ready=%0b valid=%0b required 1 0", o_ready, o_valid);
    end
    expect_quiet(40, "flush_no_valid");
    do_op(3'd0, 32'd3, 32'd5, 0, "mul_after_flush");
    i_funct3 = 3'd0; i_op1 = 32'd9; i_op2 = 32'd9; i_valid = 1'b1; i_flush = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    expect_quiet(40, "flush_blocks_accept");
    $display("[TB] flush checked");
  endtask

  task automatic test_async_reset();
    i_funct3 = 3'd1; i_op1 = 32'hCAFE_0001; i_op2 = 32'h0000_7777; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    i_reset_n = 1'b0;
    #1;
    tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 32'd0) begin
      fails++;
      $display("FAIL async_reset: ready=%0b valid=%0b result=%08h required 1 0 0", o_ready, o_valid, o_result);
    end
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    expect_quiet(40, "reset_no_valid");
    do_op(3'd5, 32'd9, 32'd0, 0, "divu_zero_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int n = 0; n < 8; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = (n == 2) ? 32'd0 : $urandom;
      b  = (n == 5) ? 32'd0 : (n == 6) ? 32'd3 : $urandom;
      do_op(f3, a, b, 0, "b2b");
    end
  endtask

  initial begin
    i_reset_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_funct3 = 3'd0; i_op1 = 32'd0; i_op2 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_mul();
    test_div();
    test_boundary();
    test_hold();
    test_flush();
    test_async_reset();
    test_back_to_back();
    tests++;
    if (scoreboard.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d left, required 0", scoreboard.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
